// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor family: counter states, FSM states
// and the counter value written by the post-reset clear sweep.
package branch_predictor_pkg;

  localparam int unsigned CTR_BITS = 2;

  localparam logic [CTR_BITS-1:0] BP_SNT = 2'b00;
  localparam logic [CTR_BITS-1:0] BP_WNT = 2'b01;
  localparam logic [CTR_BITS-1:0] BP_WT  = 2'b10;
  localparam logic [CTR_BITS-1:0] BP_ST  = 2'b11;

  localparam logic [CTR_BITS-1:0] BP_CTR_INIT = BP_WNT;

  localparam logic [0:0] BP_STATE_INIT  = 1'b0;
  localparam logic [0:0] BP_STATE_READY = 1'b1;

  // A counter predicts taken when it sits in either taken state.
  function automatic logic bp_predict_taken(input logic [CTR_BITS-1:0] ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/sat_counter_2bit.sv
// Two-bit saturating counter next-state function; purely combinational so it
// can be shared by any predictor that keeps its own counter storage.
module sat_counter_2bit
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != BP_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter predictor with a tagged BTB. Lookup is
// combinational in IF, training happens at the clock edge from EX.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            branch_estimation,
  output logic [XLEN-1:0] predicted_pc,
  input  logic            ex_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  output logic            init_busy
);

  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = XLEN - INDEX_BITS - 2;

  logic [0:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_idx_q, sweep_idx_d;

  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];
  logic [XLEN-1:0]       target_q [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic                  ready, if_hit, ex_hit;
  logic [CTR_BITS-1:0]   ctr_upd;
  logic                  unused_pc_bits;

  // State register for the clear sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BP_STATE_INIT;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      BP_STATE_INIT: begin
        sweep_idx_d = sweep_idx_q + INDEX_BITS'(1);
        if (sweep_idx_q == INDEX_BITS'(ENTRIES - 1)) state_d = BP_STATE_READY;
      end
      default: ;
    endcase
  end

  assign ready     = (state_q == BP_STATE_READY) && !reset;
  assign init_busy = !ready;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[XLEN-1:INDEX_BITS+2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[XLEN-1:INDEX_BITS+2];

  // Byte offsets within a 4-byte instruction never select an entry.
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Zero-latency lookup sees the pre-update entry; no same-cycle bypass.
  assign if_hit            = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign branch_estimation = ready && if_hit && bp_predict_taken(ctr_q[if_idx]);
  assign predicted_pc      = branch_estimation ? target_q[if_idx] : if_pc + XLEN'(4);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  sat_counter_2bit u_ctr (
    .ctr      (ctr_q[ex_idx]),
    .taken    (ex_branch_taken),
    .ctr_next (ctr_upd)
  );

  // Table storage: cleared by the sweep, trained from EX once ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == BP_STATE_INIT) begin
        valid_q[sweep_idx_q] <= 1'b0;
        ctr_q[sweep_idx_q]   <= BP_CTR_INIT;
      end else if (ex_branch) begin
        if (ex_hit) begin
          ctr_q[ex_idx] <= ctr_upd;
          if (ex_branch_taken) target_q[ex_idx] <= ex_branch_target;
        end else if (ex_branch_taken) begin
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= ex_branch_target;
          ctr_q[ex_idx]    <= BP_WT;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand-written reset/INIT
// sequences and randomized traffic against a behavioural table model.
module tb_branch_predictor;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRIES = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] if_pc;
  logic            branch_estimation;
  logic [XLEN-1:0] predicted_pc;
  logic            ex_branch;
  logic [XLEN-1:0] ex_pc;
  logic            ex_branch_taken;
  logic [XLEN-1:0] ex_branch_target;
  logic            init_busy;

  int vectors     = 0;
  int miscompares = 0;

  branch_predictor #(.XLEN(XLEN), .INDEX_BITS(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .branch_estimation(branch_estimation),
    .predicted_pc     (predicted_pc),
    .ex_branch        (ex_branch),
    .ex_pc            (ex_pc),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .init_busy        (init_busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: per-index valid/tag/counter(0..3)/target plus cycles of clearing left.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_init_left = ENTRIES;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> 6;
  endfunction

  function automatic bit m_busy();
    return reset || (m_init_left > 0);
  endfunction

  function automatic bit m_est(input logic [31:0] pc);
    int unsigned i;
    i = idx_of(pc);
    return !m_busy() && m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred(input logic [31:0] pc);
    logic [31:0] seq;
    seq = pc + 32'd4;
    return m_est(pc) ? m_tgt[idx_of(pc)] : seq;
  endfunction

  // Apply what the coming clock edge does to the predictor's contents.
  task automatic model_edge();
    int unsigned i;
    if (reset) begin
      m_init_left = ENTRIES;
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else if (ex_branch) begin
      i = idx_of(ex_pc);
      if (m_valid[i] && m_tag[i] == tag_of(ex_pc)) begin
        if (ex_branch_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = ex_branch_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (ex_branch_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(ex_pc);
        m_tgt[i]   = ex_branch_target;
        m_ctr[i]   = 2;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_model(input string name);
    chk({name, "/busy"}, 32'(init_busy), 32'(m_busy()));
    chk({name, "/est"},  32'(branch_estimation), 32'(m_est(if_pc)));
    chk({name, "/pc"},   predicted_pc, m_pred(if_pc));
  endtask

  task automatic drive(input bit b, input logic [31:0] pc, input bit t,
                       input logic [31:0] tgt, input logic [31:0] fpc);
    ex_branch        = b;
    ex_pc            = pc;
    ex_branch_taken  = t;
    ex_branch_target = tgt;
    if_pc            = fpc;
    #1;
  endtask

  typedef struct {
    bit          b;
    logic [31:0] pc;
    bit          t;
    logic [31:0] tgt;
    logic [31:0] fpc;
    bit          exp_est;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[19];

  initial begin
    // Each row: EX update and IF lookup in the same cycle; expectations are pre-edge.
    vecs[0]  = '{1, 32'h1000, 1, 32'h1100, 32'h1000, 0, 32'h1004};
    vecs[1]  = '{0, 32'h0,    0, 32'h0,    32'h1000, 1, 32'h1100};
    vecs[2]  = '{1, 32'h1000, 1, 32'h1100, 32'h1000, 1, 32'h1100};
    vecs[3]  = '{1, 32'h1000, 1, 32'h1100, 32'h1000, 1, 32'h1100};
    vecs[4]  = '{1, 32'h1000, 1, 32'h1100, 32'h1000, 1, 32'h1100};
    vecs[5]  = '{1, 32'h1000, 0, 32'h0,    32'h1000, 1, 32'h1100};
    vecs[6]  = '{1, 32'h1000, 0, 32'h0,    32'h1000, 1, 32'h1100};
    vecs[7]  = '{1, 32'h1000, 0, 32'h0,    32'h1000, 0, 32'h1004};
    vecs[8]  = '{1, 32'h1000, 0, 32'h0,    32'h1000, 0, 32'h1004};
    vecs[9]  = '{1, 32'h1000, 1, 32'h1100, 32'h1000, 0, 32'h1004};
    vecs[10] = '{1, 32'h1000, 1, 32'h1100, 32'h1000, 0, 32'h1004};
    vecs[11] = '{0, 32'h0,    0, 32'h0,    32'h1000, 1, 32'h1100};
    vecs[12] = '{1, 32'h1040, 1, 32'h2000, 32'h1000, 1, 32'h1100};
    vecs[13] = '{0, 32'h0,    0, 32'h0,    32'h1040, 1, 32'h2000};
    vecs[14] = '{0, 32'h0,    0, 32'h0,    32'h1000, 0, 32'h1004};
    vecs[15] = '{1, 32'h1200, 0, 32'h0,    32'h1200, 0, 32'h1204};
    vecs[16] = '{0, 32'h0,    0, 32'h0,    32'h1200, 0, 32'h1204};
    vecs[17] = '{0, 32'h0,    0, 32'h0,    32'h1040, 1, 32'h2000};
    vecs[18] = '{0, 32'h0,    0, 32'h0,    32'hFFFF_FFFC, 0, 32'h0000_0000};

    reset = 1'b1;
    drive(0, 32'h0, 0, 32'h0, 32'h1000);
    @(negedge clk);
    tick();
    chk("reset/busy", 32'(init_busy), 32'h1);
    chk("reset/est", 32'(branch_estimation), 32'h0);

    // Sweep: 16 busy cycles, EX pulses ignored.
    reset = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      drive(i[0], 32'h1000, 1, 32'h1100, 32'h1000);
      chk($sformatf("init%0d/busy", i), 32'(init_busy), 32'h1);
      chk($sformatf("init%0d/est", i), 32'(branch_estimation), 32'h0);
      chk($sformatf("init%0d/pc", i), predicted_pc, 32'h1004);
      tick();
    end
    drive(0, 32'h0, 0, 32'h0, 32'h1000);
    chk("ready/busy", 32'(init_busy), 32'h0);
    chk("ready/est", 32'(branch_estimation), 32'h0);
    chk("ready/pc", predicted_pc, 32'h1004);

    foreach (vecs[i]) begin
      drive(vecs[i].b, vecs[i].pc, vecs[i].t, vecs[i].tgt, vecs[i].fpc);
      chk($sformatf("vec%0d/est", i), 32'(branch_estimation), 32'(vecs[i].exp_est));
      chk($sformatf("vec%0d/pc", i), predicted_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d/busy", i), 32'(init_busy), 32'h0);
      tick();
    end

    // Train, then reset on cycle 5 of a fresh sweep.
    drive(1, 32'h1000, 1, 32'h1100, 32'h1000);
    tick();
    drive(0, 32'h0, 0, 32'h0, 32'h1000);
    chk("trained/est", 32'(branch_estimation), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("midsweep/busy", 32'(init_busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      drive(1, 32'h1000, 1, 32'h1100, 32'h1000);
      chk($sformatf("resweep%0d/busy", i), 32'(init_busy), 32'h1);
      tick();
    end
    drive(0, 32'h0, 0, 32'h0, 32'h1000);
    chk("resweep_done/busy", 32'(init_busy), 32'h0);
    chk("resweep_done/est", 32'(branch_estimation), 32'h0);
    chk("resweep_done/pc", predicted_pc, 32'h1004);

    // Random traffic over a few aliasing tags, occasional resets.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] tags [4];
      logic [31:0] epc, fpc, tgt;
      tags[0] = 32'h40; tags[1] = 32'h41; tags[2] = 32'h48; tags[3] = 32'h3FF_FFFF;
      epc = (tags[$urandom_range(3)] << 6) | 32'($urandom_range(15) << 2) | 32'($urandom_range(3));
      fpc = (tags[$urandom_range(3)] << 6) | 32'($urandom_range(15) << 2) | 32'($urandom_range(3));
      tgt = $urandom & 32'hFFFF_FFFC;
      reset = ($urandom_range(199) == 0);
      drive($urandom_range(1) == 1, epc, $urandom_range(2) != 0, tgt, fpc);
      chk_model($sformatf("rand%0d", n));
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
